mac_accum_bank: RTL

Parametrised successor to the single-channel 4-slot MAC. It performs multiply-accumulate into NUM_BANKS partial-sum banks, with these additions:
- selectable signed arithmetic;
- zero-operand skipping for sparse activations and weights;
- a registered multiply pipeline;
- a valid/ready drain sequencer that streams bank contents out in order, then clears them.

It sits between the sparse operand dispatcher and the output-channel writeback buffer in each PE column.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_mult_stage.sv | 65 ++++++
 rtl/mac_accum_bank.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC accumulator bank.
package mac_pkg;

  localparam int SKIP_CNT_WIDTH = 16;

  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;

  // Works from the MSBs alone: the carry out of the top bit is recovered
  // from a, b and the sum bit, so no extra adder bit is needed.
  function automatic logic ovf_add(input logic a, input logic b, input logic sum,
                                   input logic signed_mode);
    if (signed_mode) return (a == b) && (sum != a);
    return (a & b) | ((a ^ b) & ~sum);
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// S1: zero-skip detection, range check on the bank index, and a registered
// signed/unsigned multiply sign- or zero-extended to the accumulator width.
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_BANKS  = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int SIGNED     = 0
) (
  input  logic                      Clk,
  input  logic                      rst,
  input  logic                      take,
  input  logic [DATA_WIDTH-1:0]     act,
  input  logic [DATA_WIDTH-1:0]     weight,
  input  logic [SEL_WIDTH-1:0]      sel,
  input  logic                      first,
  output logic                      valid,
  output logic [ACC_WIDTH-1:0]      prod,
  output logic [SEL_WIDTH-1:0]      sel_q,
  output logic                      first_q,
  output logic [SKIP_CNT_WIDTH-1:0] skip_count
);

  logic                 zero, in_range;
  logic [ACC_WIDTH-1:0] prod_d;

  assign zero     = (act == '0) || (weight == '0);
  assign in_range = int'(sel) < NUM_BANKS;

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*DATA_WIDTH-1:0] p;
      assign p = $signed({{DATA_WIDTH{act[DATA_WIDTH-1]}}, act}) *
                 $signed({{DATA_WIDTH{weight[DATA_WIDTH-1]}}, weight});
      assign prod_d = ACC_WIDTH'(p);
    end else begin : g_unsigned
      logic [2*DATA_WIDTH-1:0] p;
      assign p = {{DATA_WIDTH{1'b0}}, act} * {{DATA_WIDTH{1'b0}}, weight};
      assign prod_d = ACC_WIDTH'(p);
    end
  endgenerate

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      valid      <= 1'b0;
      prod       <= '0;
      sel_q      <= '0;
      first_q    <= 1'b0;
      skip_count <= '0;
    end else begin
      valid <= take && in_range && !zero;
      if (take && in_range && !zero) begin
        prod    <= prod_d;
        sel_q   <= sel;
        first_q <= first;
      end
      // Out-of-range pairs are dropped silently and never counted as skips.
      if (take && in_range && zero && skip_count != '1)
        skip_count <= skip_count + SKIP_CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mac_accum_bank.sv
// Multiply-accumulate into NUM_BANKS partial-sum banks with zero skipping,
// sticky per-bank overflow and a valid/ready drain that clears banks as sent.
module mac_accum_bank
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_BANKS  = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_BANKS),
  parameter int SIGNED     = 0
) (
  input  logic                      Clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_act,
  input  logic [DATA_WIDTH-1:0]     in_weight,
  input  logic [SEL_WIDTH-1:0]      in_sel,
  input  logic                      in_first,
  input  logic                      drain_start,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic [SEL_WIDTH-1:0]      out_bank,
  output logic                      out_ovf,
  output logic                      busy,
  output logic [SKIP_CNT_WIDTH-1:0] skip_count
);

  state_t                                state;
  logic                                  take, drain_fire;
  logic                                  s1_valid, s1_first, s2_valid, s2_first;
  logic [ACC_WIDTH-1:0]                  s1_prod, s2_prod;
  logic [SEL_WIDTH-1:0]                  s1_sel, s2_sel;
  logic [NUM_BANKS-1:0][ACC_WIDTH-1:0]   bank;
  logic [NUM_BANKS-1:0]                  ovf;
  logic [ACC_WIDTH-1:0]                  acc_base, acc_sum;
  logic                                  acc_ovf;

  assign in_ready   = (state == ACCUM);
  assign take       = in_valid && in_ready;
  assign drain_fire = out_valid && out_ready;
  assign busy       = s1_valid || s2_valid || (state != ACCUM);

  mac_mult_stage #(
    .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .NUM_BANKS(NUM_BANKS),
    .SEL_WIDTH(SEL_WIDTH), .SIGNED(SIGNED)
  ) u_mult (
    .Clk(Clk), .rst(rst), .take(take), .act(in_act), .weight(in_weight),
    .sel(in_sel), .first(in_first), .valid(s1_valid), .prod(s1_prod),
    .sel_q(s1_sel), .first_q(s1_first), .skip_count(skip_count)
  );

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_sel   <= '0;
      s2_first <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod  <= s1_prod;
        s2_sel   <= s1_sel;
        s2_first <= s1_first;
      end
    end
  end

  // One shared adder: only the bank addressed by S2 changes in a cycle, and
  // it reads the live register so back-to-back hits on one bank need no stall.
  assign acc_base = s2_first ? '0 : bank[s2_sel];
  assign acc_sum  = acc_base + s2_prod;
  assign acc_ovf  = (!s2_first && ovf[s2_sel]) ||
                    ovf_add(acc_base[ACC_WIDTH-1], s2_prod[ACC_WIDTH-1],
                            acc_sum[ACC_WIDTH-1], SIGNED != 0);

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      bank <= '0;
      ovf  <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (drain_fire && int'(out_bank) == b) begin
          bank[b] <= '0;
          ovf[b]  <= 1'b0;
        end else if (s2_valid && int'(s2_sel) == b) begin
          bank[b] <= acc_sum;
          ovf[b]  <= acc_ovf;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state     <= ACCUM;
      out_valid <= 1'b0;
      out_bank  <= '0;
    end else begin
      case (state)
        ACCUM: if (drain_start) state <= FLUSH;
        FLUSH: if (!s1_valid && !s2_valid) begin
          state     <= DRAIN;
          out_valid <= 1'b1;
          out_bank  <= '0;
        end
        DRAIN: if (out_ready) begin
          if (out_bank == SEL_WIDTH'(NUM_BANKS - 1)) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            out_bank  <= '0;
          end else begin
            out_bank <= out_bank + SEL_WIDTH'(1);
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // Banks cannot change during DRAIN, so the mux output is stable under backpressure.
  assign out_data = out_valid ? bank[out_bank] : '0;
  assign out_ovf  = out_valid ? ovf[out_bank] : 1'b0;

endmodule
